// File: rtl/seven_segment_arbiter.sv
// seven_segment_arbiter
// Round-robin owner selection for a shared six-digit seven-segment display.
// A source keeps the display for DWELL cycles before the pointer moves on,
// or until it drops its own request. All outputs are registered and derived
// from the same next-state decision, so they always agree within a cycle.
module seven_segment_arbiter #(
    parameter int          NUM_REQ  = 4,
    parameter int          NUM      = 6,
    parameter int          CLOCK_HZ = 50000000,
    parameter int          DWELL_HZ = 1,
    parameter logic [3:0]  BLANK    = 4'hF,
    localparam int         IW       = ($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [NUM_REQ-1:0]                req,
    input  logic [NUM_REQ-1:0][NUM-1:0][3:0]  req_digits,
    output logic [NUM_REQ-1:0]                grant,
    output logic [IW-1:0]                     owner,
    output logic                              owner_valid,
    output logic [NUM-1:0][3:0]               digit_out,
    output logic                              switch_pulse
);

    // Dwell length in clock cycles and the counter sized to hold DWELL-1.
    localparam int DWELL = CLOCK_HZ / DWELL_HZ;
    localparam int CW    = ($clog2(DWELL) > 1) ? $clog2(DWELL) : 1;

    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

    localparam logic [IW-1:0]        IDX_ZERO   = {IW{1'b0}};
    localparam logic [NUM_REQ-1:0]   GRANT_NONE = {NUM_REQ{1'b0}};
    localparam logic [NUM-1:0][3:0]  BLANK_WORD = {NUM{BLANK}};

    // Arbiter states: nobody owns the display, or one source owns it.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_OWN  = 1'b1;

    // Index one past idx, wrapping at NUM_REQ (NUM_REQ need not be a power of two).
    function automatic logic [IW-1:0] inc_mod(input logic [IW-1:0] idx);
        if (int'(idx) >= NUM_REQ - 1) begin
            return IDX_ZERO;
        end else begin
            return idx + IW'(1);
        end
    endfunction

    // Circular search: first requesting index from start onward, optionally
    // skipping one index. Result is {hit, index}.
    function automatic logic [IW:0] rr_search(
        input logic [NUM_REQ-1:0] r,
        input logic [IW-1:0]      start,
        input logic               excl_en,
        input logic [IW-1:0]      excl
    );
        logic          found;
        logic [IW-1:0] pick;
        int            pos;
        found = 1'b0;
        pick  = IDX_ZERO;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = (int'(start) + k) % NUM_REQ;
            if (!found && r[pos] && !(excl_en && (pos == int'(excl)))) begin
                found = 1'b1;
                pick  = IW'(pos);
            end
        end
        return {found, pick};
    endfunction

    // One-hot grant vector for an owner index.
    function automatic logic [NUM_REQ-1:0] onehot(input logic [IW-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v = GRANT_NONE;
        v[idx] = 1'b1;
        return v;
    endfunction

    logic [0:0]     state_r;
    logic [0:0]     state_s;
    logic [IW-1:0]  owner_r;
    logic [IW-1:0]  owner_s;
    logic [IW-1:0]  rr_r;
    logic [IW-1:0]  rr_s;
    logic [CW-1:0]  cnt_r;
    logic [CW-1:0]  cnt_s;
    logic           pulse_s;

    logic [IW:0]    idle_pick_s;
    logic [IW:0]    own_pick_s;
    logic [IW-1:0]  after_owner_s;

    // While owning, both release and expiry look from the slot after the
    // owner and never pick the owner itself; from idle the search uses rr.
    assign after_owner_s = inc_mod(owner_r);
    assign idle_pick_s   = rr_search(req, rr_r, 1'b0, IDX_ZERO);
    assign own_pick_s    = rr_search(req, after_owner_s, 1'b1, owner_r);

    // Next-state decision: acquisition, release, dwell expiry, dwell count.
    always_comb begin
        state_s = state_r;
        owner_s = owner_r;
        rr_s    = rr_r;
        cnt_s   = cnt_r;
        pulse_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (idle_pick_s[IW]) begin
                    state_s = ST_OWN;
                    owner_s = idle_pick_s[IW-1:0];
                    rr_s    = inc_mod(idle_pick_s[IW-1:0]);
                    cnt_s   = CNT_ZERO;
                    pulse_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                    owner_s = IDX_ZERO;
                    cnt_s   = CNT_ZERO;
                end
            end
            ST_OWN: begin
                if (!req[owner_r]) begin
                    // Release wins over expiry when both happen together.
                    if (own_pick_s[IW]) begin
                        owner_s = own_pick_s[IW-1:0];
                        rr_s    = inc_mod(own_pick_s[IW-1:0]);
                        cnt_s   = CNT_ZERO;
                        pulse_s = 1'b1;
                    end else begin
                        // Going idle keeps rr where the last owner left it.
                        state_s = ST_IDLE;
                        owner_s = IDX_ZERO;
                        cnt_s   = CNT_ZERO;
                    end
                end else if (cnt_r == CNT_LAST) begin
                    if (own_pick_s[IW]) begin
                        owner_s = own_pick_s[IW-1:0];
                        rr_s    = inc_mod(own_pick_s[IW-1:0]);
                        cnt_s   = CNT_ZERO;
                        pulse_s = 1'b1;
                    end else begin
                        // Nobody else waiting: owner starts a fresh dwell quietly.
                        cnt_s   = CNT_ZERO;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                owner_s = IDX_ZERO;
                rr_s    = IDX_ZERO;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // Arbiter state registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
            owner_r <= IDX_ZERO;
            rr_r    <= IDX_ZERO;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_s;
            owner_r <= owner_s;
            rr_r    <= rr_s;
            cnt_r   <= cnt_s;
        end
    end

    // Ownership outputs, all taken from the same next-state decision.
    always_ff @(posedge clock) begin
        if (reset) begin
            grant        <= GRANT_NONE;
            owner        <= IDX_ZERO;
            owner_valid  <= 1'b0;
            switch_pulse <= 1'b0;
        end else begin
            grant        <= (state_s == ST_OWN) ? onehot(owner_s) : GRANT_NONE;
            owner        <= owner_s;
            owner_valid  <= (state_s == ST_OWN);
            switch_pulse <= pulse_s;
        end
    end

    // Display mux one cycle behind the grant; owner digits pass through live.
    always_ff @(posedge clock) begin
        if (reset) begin
            digit_out <= BLANK_WORD;
        end else if (owner_valid) begin
            digit_out <= req_digits[owner];
        end else begin
            digit_out <= BLANK_WORD;
        end
    end

endmodule

// File: tb/tb_seven_segment_arbiter.sv
// Bench for seven_segment_arbiter: directed scenarios plus a randomized run,
// all checked against a cycle-level model of the ownership rules.
module tb_seven_segment_arbiter;

    localparam int NR    = 4;
    localparam int ND    = 6;
    localparam int DWELL = 10;
    localparam logic [ND-1:0][3:0] BLANKS = {ND{4'hF}};

    logic                         clock = 1'b0;
    logic                         reset = 1'b1;
    logic [NR-1:0]                req = 4'b0000;
    logic [NR-1:0][ND-1:0][3:0]   req_digits = '0;
    logic [NR-1:0]                grant;
    logic [1:0]                   owner;
    logic                         owner_valid;
    logic [ND-1:0][3:0]           digit_out;
    logic                         switch_pulse;

    seven_segment_arbiter #(
        .NUM_REQ(NR), .NUM(ND), .CLOCK_HZ(20), .DWELL_HZ(2), .BLANK(4'hF)
    ) dut (
        .clock(clock), .reset(reset), .req(req), .req_digits(req_digits),
        .grant(grant), .owner(owner), .owner_valid(owner_valid),
        .digit_out(digit_out), .switch_pulse(switch_pulse)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Reference model: owner index (-1 = nobody), cycles held so far, pointer.
    int                  m_owner = -1;
    int                  m_held  = 0;
    int                  m_rr    = 0;
    bit                  m_pulse = 1'b0;
    logic [ND-1:0][3:0]  m_digits = BLANKS;
    logic [NR-1:0]       e_grant;
    logic [1:0]          e_owner;
    logic                e_valid;

    function automatic int find_req(input int start, input int excl);
        for (int k = 0; k < NR; k++) begin
            int p;
            p = (start + k) % NR;
            if (req[p] && p != excl) return p;
        end
        return -1;
    endfunction

    task automatic give(input int p);
        m_owner = p;
        m_held  = 1;
        m_pulse = 1'b1;
        m_rr    = (p + 1) % NR;
    endtask

    // Advance the model with the inputs present at the edge, then the clock.
    task automatic tick();
        int pick;
        if (reset) begin
            m_owner = -1; m_held = 0; m_rr = 0; m_pulse = 1'b0; m_digits = BLANKS;
        end else begin
            if (m_owner >= 0) m_digits = req_digits[m_owner];
            else              m_digits = BLANKS;
            m_pulse = 1'b0;
            if (m_owner < 0) begin
                pick = find_req(m_rr, -1);
                if (pick >= 0) give(pick);
            end else if (!req[m_owner]) begin
                pick = find_req(m_owner + 1, m_owner);
                if (pick >= 0) give(pick);
                else           m_owner = -1;
            end else if (m_held == DWELL) begin
                pick = find_req(m_owner + 1, m_owner);
                if (pick >= 0) give(pick);
                else           m_held = 1;
            end else begin
                m_held++;
            end
        end
        e_valid = (m_owner >= 0);
        e_owner = e_valid ? 2'(m_owner) : 2'd0;
        e_grant = e_valid ? (4'b0001 << m_owner) : 4'b0000;
        @(posedge clock);
        #1;
    endtask

    task automatic rand_digits();
        for (int s = 0; s < NR; s++)
            for (int d = 0; d < ND; d++)
                req_digits[s][d] = 4'($urandom());
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = 4'b0000;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (grant !== 4'b0000 || owner !== 2'd0 || owner_valid !== 1'b0 ||
            switch_pulse !== 1'b0 || digit_out !== BLANKS) begin
            errors++;
            $display("FAIL reset_values: grant=%b owner=%0d valid=%b pulse=%b digits=%h, required 0000/0/0/0/%h",
                     grant, owner, owner_valid, switch_pulse, digit_out, BLANKS);
        end
        for (int i = 0; i < 20; i++) begin
            rand_digits();
            tick();
            checks++;
            if (grant !== 4'b0000 || owner_valid !== 1'b0 || switch_pulse !== 1'b0 ||
                digit_out !== BLANKS) begin
                errors++;
                $display("FAIL idle_hold cycle %0d: grant=%b valid=%b pulse=%b digits=%h, required idle/blank",
                         i, grant, owner_valid, switch_pulse, digit_out);
            end
        end
    endtask

    task automatic test_single();
        do_reset();
        rand_digits();
        req_digits[2] = 24'h123456;
        req = 4'b0100;
        tick();
        checks++;
        if (grant !== 4'b0100 || owner !== 2'd2 || owner_valid !== 1'b1 || switch_pulse !== 1'b1) begin
            errors++;
            $display("FAIL single_grant: grant=%b owner=%0d valid=%b pulse=%b, required 0100/2/1/1",
                     grant, owner, owner_valid, switch_pulse);
        end
        tick();
        checks++;
        if (digit_out !== 24'h123456 || switch_pulse !== 1'b0) begin
            errors++;
            $display("FAIL single_digits: digits=%h pulse=%b, required 123456/0", digit_out, switch_pulse);
        end
        for (int i = 0; i < 30; i++) begin
            tick();
            checks++;
            if (grant !== 4'b0100 || switch_pulse !== 1'b0) begin
                errors++;
                $display("FAIL single_hold cycle %0d: grant=%b pulse=%b, required 0100/0", i, grant, switch_pulse);
            end
        end
    endtask

    task automatic test_rotate();
        int who[$];
        int when[$];
        do_reset();
        req = 4'b1011;
        for (int i = 0; i <= 30; i++) begin
            tick();
            checks++;
            if (grant !== e_grant || switch_pulse !== m_pulse) begin
                errors++;
                $display("FAIL rotate_cycle %0d: grant=%b pulse=%b, required %b/%b",
                         i, grant, switch_pulse, e_grant, m_pulse);
            end
            if (switch_pulse === 1'b1) begin
                who.push_back(int'(owner));
                when.push_back(i);
            end
        end
        checks++;
        if (who.size() != 4) begin
            errors++;
            $display("FAIL rotate_pulses: got %0d pulses, required 4", who.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                int want;
                want = (k == 2) ? 3 : ((k == 1) ? 1 : 0);
                checks++;
                if (who[k] != want || when[k] != 10 * k) begin
                    errors++;
                    $display("FAIL rotate_order %0d: owner %0d at cycle %0d, required owner %0d at cycle %0d",
                             k, who[k], when[k], want, 10 * k);
                end
            end
        end
    endtask

    task automatic test_release();
        logic [ND-1:0][3:0] src1;
        do_reset();
        rand_digits();
        req = 4'b1010;
        for (int i = 0; i < 4; i++) tick();
        req = 4'b1000;
        tick();
        checks++;
        if (grant !== 4'b1000 || owner_valid !== 1'b1 || switch_pulse !== 1'b1 || owner !== 2'd3) begin
            errors++;
            $display("FAIL release_handover: grant=%b valid=%b pulse=%b owner=%0d, required 1000/1/1/3",
                     grant, owner_valid, switch_pulse, owner);
        end
        do_reset();
        rand_digits();
        src1 = req_digits[1];
        req = 4'b0010;
        for (int i = 0; i < 4; i++) tick();
        req = 4'b0000;
        tick();
        checks++;
        if (grant !== 4'b0000 || owner_valid !== 1'b0 || switch_pulse !== 1'b0 || digit_out !== src1) begin
            errors++;
            $display("FAIL release_idle: grant=%b valid=%b pulse=%b digits=%h, required 0000/0/0/%h",
                     grant, owner_valid, switch_pulse, digit_out, src1);
        end
        tick();
        checks++;
        if (digit_out !== BLANKS) begin
            errors++;
            $display("FAIL release_blank: digits=%h, required %h", digit_out, BLANKS);
        end
    endtask

    task automatic test_expiry_wrap();
        do_reset();
        req = 4'b1000;
        for (int i = 0; i < 10; i++) tick();
        req = 4'b1001;
        tick();
        checks++;
        if (grant !== 4'b0001 || switch_pulse !== 1'b1) begin
            errors++;
            $display("FAIL wrap_on_expiry: grant=%b pulse=%b, required 0001/1", grant, switch_pulse);
        end
        do_reset();
        req = 4'b1000;
        for (int i = 0; i < 11; i++) tick();
        req = 4'b1001;
        for (int i = 11; i < 20; i++) begin
            tick();
            checks++;
            if (grant !== 4'b1000 || switch_pulse !== 1'b0) begin
                errors++;
                $display("FAIL late_keep cycle %0d: grant=%b pulse=%b, required 1000/0", i, grant, switch_pulse);
            end
        end
        tick();
        checks++;
        if (grant !== 4'b0001 || switch_pulse !== 1'b1) begin
            errors++;
            $display("FAIL late_wrap: grant=%b pulse=%b, required 0001/1", grant, switch_pulse);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        rand_digits();
        req = 4'b0100;
        for (int i = 0; i < 6; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (grant !== 4'b0000 || owner_valid !== 1'b0 || owner !== 2'd0 ||
            switch_pulse !== 1'b0 || digit_out !== BLANKS) begin
            errors++;
            $display("FAIL reset_mid: grant=%b valid=%b owner=%0d pulse=%b digits=%h, required idle/blank",
                     grant, owner_valid, owner, switch_pulse, digit_out);
        end
        req = 4'b0110;
        tick();
        checks++;
        if (grant !== 4'b0010 || switch_pulse !== 1'b1) begin
            errors++;
            $display("FAIL reset_rr: grant=%b pulse=%b, required 0010/1", grant, switch_pulse);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(3) == 0) req = 4'($urandom());
            reset = ($urandom_range(199) == 0);
            rand_digits();
            tick();
            checks++;
            if (grant !== e_grant || owner !== e_owner || owner_valid !== e_valid ||
                switch_pulse !== m_pulse || digit_out !== m_digits) begin
                errors++;
                $display("FAIL random cycle %0d: grant=%b owner=%0d valid=%b pulse=%b digits=%h, required %b/%0d/%b/%b/%h",
                         i, grant, owner, owner_valid, switch_pulse, digit_out,
                         e_grant, e_owner, e_valid, m_pulse, m_digits);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_rotate();
        test_release();
        test_expiry_wrap();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
